div_iter_axis: RTL and testbench

- Multi-cycle radix-2 restoring divider for the EXE stage; synthesizable replacement for the vendor divider IP.
- Acts as the responder on the divider stream interface: accepts divisor and dividend on independent valid/ready channels and returns {quotient, remainder} on a valid-only output channel.
- One instance per signedness (SIGNED=1 for DIV, SIGNED=0 for DIVU), driven by the EXE stage's one-shot tvalid launch logic.

---
 rtl/div_iter_axis_if.sv | 29 ++
 rtl/div_iter_axis.sv | 117 +++++++++++
 tb/tb_div_iter_axis.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_axis_if.sv
// Divider stream bundle: two operand channels (valid/ready) and a valid-only result channel.
interface div_iter_axis_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   s_axis_divisor_tdata;
    logic               s_axis_divisor_tvalid;
    logic               s_axis_divisor_tready;
    logic [WIDTH-1:0]   s_axis_dividend_tdata;
    logic               s_axis_dividend_tvalid;
    logic               s_axis_dividend_tready;
    logic [2*WIDTH-1:0] m_axis_dout_tdata;
    logic               m_axis_dout_tvalid;

    modport slave (
        input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
        output s_axis_divisor_tready,
        input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
        output s_axis_dividend_tready,
        output m_axis_dout_tdata, m_axis_dout_tvalid
    );

    modport master (
        output s_axis_divisor_tdata, s_axis_divisor_tvalid,
        input  s_axis_divisor_tready,
        output s_axis_dividend_tdata, s_axis_dividend_tvalid,
        input  s_axis_dividend_tready,
        input  m_axis_dout_tdata, m_axis_dout_tvalid
    );
endinterface

// File: rtl/div_iter_axis.sv
// Multi-cycle radix-2 restoring divider (one quotient bit per cycle) with stream handshakes.
// Optional macro DIV_EARLY_TREADY_EN: also accept the next operand pair during the DONE strobe.
module div_iter_axis #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    div_iter_axis_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
        return (SIGNED && x[WIDTH-1]) ? WIDTH'(-x) : x;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? WIDTH'(~x + 1'b1) : x;
    endfunction

    state_t state_q, state_d;
    logic   dvs_cap_q, dvd_cap_q;
    logic   accept, dvs_fire, dvd_fire, load, last;
    logic [5:0] cnt_q;

    logic signed [WIDTH-1:0] dvs_hold, dvd_hold, dvs_op, dvd_op;
    logic [WIDTH-1:0]   rem_q, quo_q, dvs_mag_q, dvd_raw_q, rem_nx;
    logic [WIDTH:0]     rem_sh;
    logic               ge, qneg_q, rneg_q, dvz_q;
    logic [WIDTH-1:0]   quo_nx;
    logic [2*WIDTH-1:0] dout_q;

    assign bus.s_axis_divisor_tready  = accept && !dvs_cap_q;
    assign bus.s_axis_dividend_tready = accept && !dvd_cap_q;
    assign dvs_fire = bus.s_axis_divisor_tvalid  && bus.s_axis_divisor_tready;
    assign dvd_fire = bus.s_axis_dividend_tvalid && bus.s_axis_dividend_tready;
    // Second operand may arrive on the same edge that loads the datapath
    assign load   = accept && (dvs_cap_q || dvs_fire) && (dvd_cap_q || dvd_fire);
    assign dvs_op = dvs_fire ? bus.s_axis_divisor_tdata  : dvs_hold;
    assign dvd_op = dvd_fire ? bus.s_axis_dividend_tdata : dvd_hold;
    assign last   = (state_q == CALC) && (cnt_q == LAST);

    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign ge     = rem_sh >= {1'b0, dvs_mag_q};
    assign rem_nx = ge ? WIDTH'(rem_sh - {1'b0, dvs_mag_q}) : rem_sh[WIDTH-1:0];
    assign quo_nx = {quo_q[WIDTH-2:0], ge};

    assign bus.m_axis_dout_tdata  = dout_q;
    assign bus.m_axis_dout_tvalid = (state_q == DONE);

    always_comb begin
        state_d = state_q;
`ifdef DIV_EARLY_TREADY_EN
        accept  = !reset && (state_q == IDLE || state_q == DONE);
`else
        accept  = !reset && (state_q == IDLE);
`endif
        case (state_q)
            IDLE:    if (load) state_d = CALC;
            CALC:    if (cnt_q == LAST) state_d = DONE;
`ifdef DIV_EARLY_TREADY_EN
            DONE:    state_d = load ? CALC : IDLE;
`else
            DONE:    state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            dvs_cap_q <= 1'b0;
            dvd_cap_q <= 1'b0;
            cnt_q     <= '0;
            dout_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                dvs_cap_q <= 1'b0;
                dvd_cap_q <= 1'b0;
            end else begin
                if (dvs_fire) dvs_cap_q <= 1'b1;
                if (dvd_fire) dvd_cap_q <= 1'b1;
            end
            if (load)
                cnt_q <= '0;
            else if (state_q == CALC)
                cnt_q <= cnt_q + 6'd1;
            // Final iteration result is corrected and registered straight into the output
            if (last)
                dout_q <= dvz_q ? {{WIDTH{1'b1}}, dvd_raw_q}
                                : {cond_neg(quo_nx, qneg_q), cond_neg(rem_nx, rneg_q)};
        end
    end

    always_ff @(posedge clk) begin
        if (dvs_fire) dvs_hold <= dvs_op;
        if (dvd_fire) dvd_hold <= dvd_op;
        if (load) begin
            rem_q     <= '0;
            quo_q     <= mag(dvd_op);
            dvs_mag_q <= mag(dvs_op);
            qneg_q    <= SIGNED && (dvd_op[WIDTH-1] ^ dvs_op[WIDTH-1]);
            rneg_q    <= SIGNED && dvd_op[WIDTH-1];
            dvz_q     <= (dvs_op == '0);
            dvd_raw_q <= dvd_op;
        end else if (state_q == CALC) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
        end
    end

endmodule

// File: tb/tb_div_iter_axis.sv
// Directed bench for div_iter_axis: one unsigned and one signed instance, exact-cycle checks.
module tb_div_iter_axis;

`ifdef DIV_EARLY_TREADY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    div_iter_axis_if #(.WIDTH(32)) bu ();
    div_iter_axis_if #(.WIDTH(32)) bs ();

    div_iter_axis #(.WIDTH(32), .SIGNED(1'b0)) dut_u (.clk(clk), .reset(reset), .bus(bu));
    div_iter_axis #(.WIDTH(32), .SIGNED(1'b1)) dut_s (.clk(clk), .reset(reset), .bus(bs));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit m, input bit sv, input logic [31:0] sd,
                          input bit dv, input logic [31:0] dd);
        if (m) begin
            bs.s_axis_divisor_tvalid = sv;  bs.s_axis_divisor_tdata  = sd;
            bs.s_axis_dividend_tvalid = dv; bs.s_axis_dividend_tdata = dd;
        end else begin
            bu.s_axis_divisor_tvalid = sv;  bu.s_axis_divisor_tdata  = sd;
            bu.s_axis_dividend_tvalid = dv; bu.s_axis_dividend_tdata = dd;
        end
    endtask

    function automatic logic vld(input bit m);
        return m ? bs.m_axis_dout_tvalid : bu.m_axis_dout_tvalid;
    endfunction
    function automatic logic [63:0] dout(input bit m);
        return m ? bs.m_axis_dout_tdata : bu.m_axis_dout_tdata;
    endfunction
    function automatic logic [1:0] rdy(input bit m);
        return m ? {bs.s_axis_divisor_tready, bs.s_axis_dividend_tready}
                 : {bu.s_axis_divisor_tready, bu.s_axis_dividend_tready};
    endfunction

    // MIPS DIV/DIVU reference with the block's divide-by-zero convention
    function automatic logic [63:0] ref_div(input bit m, input logic [31:0] b, input logic [31:0] a);
        int sa, sb, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!m) return {a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
        sa = a; sb = b;
        q = sa / sb; r = sa % sb;
        return {q, r};
    endfunction

    // Same-cycle launch at T; strobe expected exactly at T+33
    task automatic run_op(input string tag, input bit m, input logic [31:0] dvs,
                          input logic [31:0] dvd, input logic [63:0] exp);
        set_in(m, 1'b1, dvs, 1'b1, dvd);
        chk({tag, "_rdy_T"}, 64'(rdy(m)), 64'd3);
        step();
        set_in(m, 1'b0, 32'd0, 1'b0, 32'd0);
        chk({tag, "_rdy_T1"}, 64'(rdy(m)), 64'd0);
        repeat (31) step();
        chk({tag, "_vld_T32"}, 64'(vld(m)), 64'd0);
        step();
        chk({tag, "_vld_T33"}, 64'(vld(m)), 64'd1);
        chk({tag, "_data"}, dout(m), exp);
        chk({tag, "_rdy_done"}, 64'(rdy(m)), EARLY ? 64'd3 : 64'd0);
        step();
        chk({tag, "_vld_T34"}, 64'(vld(m)), 64'd0);
        chk({tag, "_hold"}, dout(m), exp);
        chk({tag, "_rdy_T34"}, 64'(rdy(m)), 64'd3);
    endtask

    initial begin
        int strobes, lat, gap;
        bit ord;
        logic [31:0] a, b;

        reset = 1'b1;
        set_in(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        set_in(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step(); step();
        chk("rst_rdy_u", 64'(rdy(0)), 64'd0);
        chk("rst_rdy_s", 64'(rdy(1)), 64'd0);
        chk("rst_vld_u", 64'(vld(0)), 64'd0);
        chk("rst_data_u", dout(0), 64'd0);
        chk("rst_data_s", dout(1), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_rdy", 64'(rdy(0)), 64'd3);

        run_op("u_100_7", 1'b0, 32'd7, 32'd100, {32'd14, 32'd2});
        step();
        chk("u_rdy_T35", 64'(rdy(0)), 64'd3);

        run_op("s_m7_2", 1'b1, 32'd2, 32'hFFFF_FFF9, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        run_op("s_7_m2", 1'b1, 32'hFFFF_FFFE, 32'd7, {32'hFFFF_FFFD, 32'd1});
        run_op("u_big", 1'b0, 32'h0000_0003, 32'hFFFF_FFFF, {32'h5555_5555, 32'd0});
        run_op("u_dz", 1'b0, 32'd0, 32'h1234_5678, {32'hFFFF_FFFF, 32'h1234_5678});
        run_op("s_dz", 1'b1, 32'd0, 32'h1234_5678, {32'hFFFF_FFFF, 32'h1234_5678});
        run_op("s_dz_neg", 1'b1, 32'd0, 32'h8000_0005, {32'hFFFF_FFFF, 32'h8000_0005});

        // Staggered: dividend at cycle 0, divisor at cycle 5, dividend channel kept busy meanwhile
        set_in(1'b1, 1'b0, 32'd0, 1'b1, 32'h8000_0000);
        step();
        for (int c = 1; c <= 5; c++) begin
            set_in(1'b1, c == 5, 32'hFFFF_FFFF, 1'b1, 32'd5);
            #1;
            chk($sformatf("stag_dvd_rdy_c%0d", c), 64'(bs.s_axis_dividend_tready), 64'd0);
            chk($sformatf("stag_dvs_rdy_c%0d", c), 64'(bs.s_axis_divisor_tready), 64'd1);
            step();
        end
        set_in(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        for (int c = 6; c < 38; c++) begin
            if (c >= 10 && c <= 12) begin
                set_in(1'b1, 1'b1, 32'd1, 1'b1, 32'd1);
                #1;
                chk($sformatf("busy_rdy_c%0d", c), 64'(rdy(1)), 64'd0);
            end else begin
                set_in(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
            end
            if (c == 37) chk("stag_vld_c37", 64'(vld(1)), 64'd0);
            step();
        end
        chk("stag_vld_c38", 64'(vld(1)), 64'd1);
        chk("stag_ovf_data", dout(1), {32'h8000_0000, 32'd0});
        step();
        chk("stag_no_extra", 64'(vld(1)), 64'd0);

        // Abort: reset in the middle of CALC
        set_in(1'b0, 1'b1, 32'd7, 1'b1, 32'd100);
        step();
        set_in(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        repeat (9) step();
        reset = 1'b1;
        #1;
        chk("abort_rdy_in_rst", 64'(rdy(0)), 64'd0);
        step();
        reset = 1'b0;
        #1;
        chk("abort_rdy_after", 64'(rdy(0)), 64'd3);
        strobes = 0;
        for (int c = 0; c < 40; c++) begin
            if (vld(0)) strobes++;
            step();
        end
        chk("abort_no_strobe", 64'(strobes), 64'd0);
        run_op("u_9_3", 1'b0, 32'd3, 32'd9, {32'd3, 32'd0});

        // Random operands with random handshake gaps and ordering
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 20; i++) begin
                a   = $urandom;
                b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
                if ($urandom_range(0, 1) == 1) b = -b;
                gap = $urandom_range(0, 3);
                ord = 1'($urandom_range(0, 1));
                if (gap == 0) begin
                    set_in(1'(m), 1'b1, b, 1'b1, a);
                end else begin
                    if (ord) set_in(1'(m), 1'b0, 32'd0, 1'b1, a);
                    else     set_in(1'(m), 1'b1, b, 1'b0, 32'd0);
                    step();
                    set_in(1'(m), 1'b0, 32'd0, 1'b0, 32'd0);
                    repeat (gap - 1) step();
                    if (ord) set_in(1'(m), 1'b1, b, 1'b0, 32'd0);
                    else     set_in(1'(m), 1'b0, 32'd0, 1'b1, a);
                end
                step();
                set_in(1'(m), 1'b0, 32'd0, 1'b0, 32'd0);
                lat = 1;
                while (!vld(1'(m)) && lat < 40) begin
                    step();
                    lat++;
                end
                chk($sformatf("rnd_m%0d_i%0d_lat", m, i), 64'(lat), 64'd33);
                chk($sformatf("rnd_m%0d_i%0d_data", m, i), dout(1'(m)), ref_div(1'(m), b, a));
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
